// File: rtl/vx_task_dispatcher_pkg.sv
// vx_task_dispatcher_pkg: shared payload, DCR address and FSM state definitions
package vx_task_dispatcher_pkg;
    localparam int TILE_W = 16;
    typedef struct packed {
        logic              last;
        logic [TILE_W-1:0] tile_y;
        logic [TILE_W-1:0] tile_x;
    } task_t;
    localparam int TASK_W = $bits(task_t);
    localparam logic [11:0] GRID_ADDR  = 12'h010;
    localparam logic [11:0] START_ADDR = 12'h011;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
endpackage

// File: rtl/vx_tile_walker.sv
// vx_tile_walker: raster-order tile coordinate counters advanced on each accepted task
module vx_tile_walker #(
    parameter int TILE_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 adv,
    input  logic [TILE_BITS-1:0] cols,
    input  logic [TILE_BITS-1:0] rows,
    output logic [TILE_BITS-1:0] x,
    output logic [TILE_BITS-1:0] y,
    output logic                 last
);
    logic wrap;
    always_comb begin
        wrap = x == cols - TILE_BITS'(1);
        last = wrap && y == rows - TILE_BITS'(1);
    end
    always_ff @(posedge clk) begin
        if (reset || init) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            x <= wrap ? '0 : x + TILE_BITS'(1);
            y <= wrap ? y + TILE_BITS'(1) : y;
        end
    end
endmodule

// File: rtl/vx_task_dispatcher.sv
// vx_task_dispatcher: DCR-started raster tile task issuer dealing clusters round-robin
module vx_task_dispatcher
    import vx_task_dispatcher_pkg::*;
#(
    parameter int          NUM_CLUSTERS   = 4,
    parameter int          TILE_BITS      = TILE_W,
    parameter logic [11:0] DCR_GRID_ADDR  = GRID_ADDR,
    parameter logic [11:0] DCR_START_ADDR = START_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dcr_write_valid,
    input  logic [11:0]              dcr_write_addr,
    input  logic [31:0]              dcr_write_data,
    output logic [NUM_CLUSTERS-1:0]  task_valid,
    output logic [2*TILE_BITS:0]     task_data,
    input  logic [NUM_CLUSTERS-1:0]  task_ready,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              task_count
);
    localparam int RRW = NUM_CLUSTERS > 1 ? $clog2(NUM_CLUSTERS) : 1;
    state_t state, state_n;
    logic [TILE_BITS-1:0] cols, rows, x, y;
    logic [RRW-1:0] rr;
    logic last, zero_done, grid_wr, start_wr, zero, hs, init;
    // DCR writes only take effect while idle
    always_comb begin
        grid_wr    = dcr_write_valid && dcr_write_addr == DCR_GRID_ADDR && state == S_IDLE;
        start_wr   = dcr_write_valid && dcr_write_addr == DCR_START_ADDR && state == S_IDLE;
        zero       = cols == '0 || rows == '0;
        init       = start_wr && !zero;
        hs         = state == S_ISSUE && task_ready[rr];
        state_n    = state == S_IDLE  ? (init ? S_ISSUE : S_IDLE) :
                     state == S_ISSUE ? (hs && last ? S_DONE : S_ISSUE) : S_IDLE;
        task_valid = state == S_ISSUE ? NUM_CLUSTERS'(1) << rr : '0;
        busy       = state != S_IDLE;
        done       = state == S_DONE || zero_done;
        task_data  = {last, y, x};
    end
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cols       <= '0;
            rows       <= '0;
            rr         <= '0;
            zero_done  <= 1'b0;
            task_count <= '0;
        end else begin
            zero_done <= start_wr && zero;
            if (grid_wr) begin
                cols <= dcr_write_data[TILE_BITS-1:0];
                rows <= dcr_write_data[16 +: TILE_BITS];
            end
            if (start_wr)  task_count <= '0;
            else if (hs)   task_count <= task_count + 32'd1;
            if (init)      rr <= '0;
            else if (hs)   rr <= rr == RRW'(NUM_CLUSTERS - 1) ? '0 : rr + RRW'(1);
        end
    end
    vx_tile_walker #(.TILE_BITS(TILE_BITS)) u_walker (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .adv   (hs),
        .cols  (cols),
        .rows  (rows),
        .x     (x),
        .y     (y),
        .last  (last)
    );
endmodule

// File: tb/tb_vx_task_dispatcher.sv
// tb_vx_task_dispatcher: directed plus randomized checks against a queue-based task list model
module tb_vx_task_dispatcher;
    localparam int NC = 3;
    localparam logic [11:0] GRID = 12'h010;
    localparam logic [11:0] START = 12'h011;
    logic clk = 1'b0;
    logic reset, dcr_write_valid, busy, done;
    logic [11:0] dcr_write_addr;
    logic [31:0] dcr_write_data, task_count;
    logic [NC-1:0] task_valid, task_ready;
    logic [32:0] task_data;
    int vectors = 0, errs = 0;
    int mode = 0, idx = 0, cols_m = 0, rows_m = 0;
    bit zdone = 0;
    logic [31:0] cnt = 0;
    logic [32:0] q[$];

    vx_task_dispatcher #(.NUM_CLUSTERS(NC), .TILE_BITS(16)) dut (
        .clk(clk), .reset(reset), .dcr_write_valid(dcr_write_valid),
        .dcr_write_addr(dcr_write_addr), .dcr_write_data(dcr_write_data),
        .task_valid(task_valid), .task_data(task_data), .task_ready(task_ready),
        .busy(busy), .done(done), .task_count(task_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // model: a start expands the grid into a list of tasks; the n-th task goes to cluster n%NC
    task automatic tick();
        bit hs, gw, st;
        hs = mode == 1 && task_ready[idx % NC] === 1'b1;
        gw = dcr_write_valid && dcr_write_addr == GRID;
        st = dcr_write_valid && dcr_write_addr == START;
        if (reset) begin
            mode = 0; zdone = 0; cnt = 0; cols_m = 0; rows_m = 0; idx = 0; q.delete();
        end else if (mode == 0) begin
            zdone = 0;
            if (gw) begin
                cols_m = int'(dcr_write_data[15:0]);
                rows_m = int'(dcr_write_data[31:16]);
            end
            if (st) begin
                cnt = 0;
                if (cols_m == 0 || rows_m == 0) zdone = 1;
                else begin
                    q.delete();
                    for (int yy = 0; yy < rows_m; yy++)
                        for (int xx = 0; xx < cols_m; xx++)
                            q.push_back({1'(xx == cols_m - 1 && yy == rows_m - 1), 16'(yy), 16'(xx)});
                    idx = 0;
                    mode = 1;
                end
            end
        end else if (mode == 1) begin
            if (hs) begin
                cnt++;
                idx++;
                if (idx == q.size()) mode = 2;
            end
        end else mode = 0;
        @(posedge clk);
        #1;
        chk("task_valid", 64'(task_valid), mode == 1 ? 64'(1) << (idx % NC) : 64'd0);
        if (mode == 1) chk("task_data", 64'(task_data), 64'(q[idx]));
        chk("busy", 64'(busy), 64'(mode != 0));
        chk("done", 64'(done), 64'(mode == 2 || zdone));
        chk("task_count", 64'(task_count), 64'(cnt));
    endtask

    task automatic dcr(input logic [11:0] a, input logic [31:0] d);
        dcr_write_valid = 1'b1;
        dcr_write_addr = a;
        dcr_write_data = d;
        tick();
        dcr_write_valid = 1'b0;
    endtask

    task automatic run(input bit rnd_ready);
        int n = 0;
        while (mode != 0 && n < 300) begin
            if (rnd_ready) task_ready = NC'($urandom);
            tick();
            n++;
        end
        vectors++;
        assert (mode == 0) else begin
            errs++;
            $error("FAIL timeout observed=busy expected=idle");
        end
    endtask

    initial begin
        reset = 1'b1; dcr_write_valid = 1'b0; dcr_write_addr = '0; dcr_write_data = '0; task_ready = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        // 2x2 grid, full throughput
        task_ready = '1;
        dcr(GRID, 32'h0002_0002);
        dcr(START, 32'hdead_beef);
        run(0);
        tick();
        // 1 col x 3 rows with cluster 0 stalled
        dcr(GRID, 32'h0003_0001);
        task_ready = 3'b110;
        dcr(START, 32'h0);
        repeat (3) tick();
        task_ready = '1;
        run(0);
        // zero grid
        dcr(GRID, 32'h0005_0000);
        dcr(START, 32'h0);
        tick(); tick();
        // 5x1 twice; second start restarts at cluster 0
        dcr(GRID, 32'h0001_0005);
        dcr(START, 32'h0);
        run(0);
        dcr(START, 32'h0);
        run(0);
        // writes during issue are ignored
        dcr(GRID, 32'h0002_0003);
        dcr(START, 32'h0);
        tick();
        dcr(GRID, 32'h0007_0007);
        dcr(START, 32'h0);
        run(0);
        // reset after two of six tasks
        dcr(START, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        dcr(GRID, 32'h0002_0003);
        dcr(START, 32'h0);
        run(0);
        // randomized grids, backpressure and stray DCR writes
        for (int r = 0; r < 14; r++) begin
            task_ready = NC'($urandom);
            dcr(GRID, {16'($urandom_range(0, 3)), 16'($urandom_range(0, 4))});
            dcr(START, $urandom);
            for (int n = 0; n < 300 && mode != 0; n++) begin
                task_ready = NC'($urandom);
                dcr_write_valid = $urandom_range(0, 7) == 0;
                dcr_write_addr = GRID + 12'($urandom_range(0, 2));
                dcr_write_data = $urandom;
                tick();
            end
            dcr_write_valid = 1'b0;
            run(1);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
